// File: rtl/hazard_ctrl_unit.sv
// Load-use / branch-flush / memory-wait hazard controller between ID and EX.
// Optional stall performance counter enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int LU_STALL   = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rs1_id,
    input  logic [REG_ADDR_W-1:0] rs2_id,
    input  logic                  rs1_used_id,
    input  logic                  rs2_used_id,
    input  logic [REG_ADDR_W-1:0] rd_ex,
    input  logic                  mem_read_ex,
    input  logic                  branch_taken_ex,
    input  logic                  dmem_ready,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  id_ex_write,
    output logic                  load_delay,
    output logic                  stall_active,
    output logic [CNT_W-1:0]      stall_cycles
);

    typedef enum logic [1:0] {RUN, LU_HOLD, MEM_WAIT} state_t;

    localparam logic [2:0] HOLD_INIT = 3'(LU_STALL - 1);

    state_t     state;
    state_t     next_state;
    logic [2:0] hold_cnt;
    logic [2:0] next_hold;
    logic       hz;

    assign hz = mem_read_ex && (rd_ex != '0) &&
                ((rs1_used_id && (rs1_id == rd_ex)) || (rs2_used_id && (rs2_id == rd_ex)));

    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        id_ex_write = 1'b1;
        load_delay  = 1'b0;
        if_id_flush = 1'b0;
        next_state  = state;
        next_hold   = hold_cnt;
        case (state)
            RUN: begin
                if (!dmem_ready) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_write = 1'b0;
                    next_state  = MEM_WAIT;
                end else if (branch_taken_ex) begin
                    if_id_flush = 1'b1;
                    load_delay  = 1'b1;
                end else if (hz) begin
                    load_delay  = 1'b1;
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    if (HOLD_INIT != 3'd0) begin
                        next_state = LU_HOLD;
                        next_hold  = HOLD_INIT;
                    end
                end
            end
            LU_HOLD: begin
                // A memory stall here freezes everything and preserves the remaining bubble count
                if (!dmem_ready) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_write = 1'b0;
                    next_state  = MEM_WAIT;
                end else begin
                    load_delay  = 1'b1;
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    next_hold   = hold_cnt - 3'd1;
                    if (hold_cnt <= 3'd1) begin
                        next_state = RUN;
                    end
                end
            end
            MEM_WAIT: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_write = 1'b0;
                if (dmem_ready) begin
                    next_state = (hold_cnt != 3'd0) ? LU_HOLD : RUN;
                end
            end
            default: begin
                next_state = RUN;
                next_hold  = 3'd0;
            end
        endcase
        if (rst) begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            id_ex_write = 1'b1;
            load_delay  = 1'b0;
            if_id_flush = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RUN;
            hold_cnt     <= 3'd0;
            stall_active <= 1'b0;
        end else begin
            state        <= next_state;
            hold_cnt     <= next_hold;
            stall_active <= (next_state != RUN);
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] perf_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cnt <= '0;
        end else if (!pc_write && (perf_cnt != {CNT_W{1'b1}})) begin
            perf_cnt <= perf_cnt + 1'b1;
        end
    end

    assign stall_cycles = perf_cnt;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: one LU_STALL=1 instance with a tiny
// saturating counter and one LU_STALL=3 instance, driven by shared inputs.
module tb_hazard_ctrl_unit;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_id, rs2_id, rd_ex;
    logic       rs1_used_id, rs2_used_id, mem_read_ex, branch_taken_ex, dmem_ready;

    logic       a_pc_write, a_if_id_write, a_if_id_flush, a_id_ex_write, a_load_delay, a_stall_active;
    logic [1:0] a_stall_cycles;
    logic       b_pc_write, b_if_id_write, b_if_id_flush, b_id_ex_write, b_load_delay, b_stall_active;
    logic [15:0] b_stall_cycles;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.REG_ADDR_W(5), .LU_STALL(1), .CNT_W(2)) dut_a (
        .clk(clk), .rst(rst),
        .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
        .rd_ex(rd_ex), .mem_read_ex(mem_read_ex),
        .branch_taken_ex(branch_taken_ex), .dmem_ready(dmem_ready),
        .pc_write(a_pc_write), .if_id_write(a_if_id_write), .if_id_flush(a_if_id_flush),
        .id_ex_write(a_id_ex_write), .load_delay(a_load_delay),
        .stall_active(a_stall_active), .stall_cycles(a_stall_cycles)
    );

    hazard_ctrl_unit #(.REG_ADDR_W(5), .LU_STALL(3), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst),
        .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
        .rd_ex(rd_ex), .mem_read_ex(mem_read_ex),
        .branch_taken_ex(branch_taken_ex), .dmem_ready(dmem_ready),
        .pc_write(b_pc_write), .if_id_write(b_if_id_write), .if_id_flush(b_if_id_flush),
        .id_ex_write(b_id_ex_write), .load_delay(b_load_delay),
        .stall_active(b_stall_active), .stall_cycles(b_stall_cycles)
    );

    task automatic applyStimulus(input logic mr, input logic [4:0] rd, input logic [4:0] r1,
                                 input logic u1, input logic [4:0] r2, input logic u2,
                                 input logic br, input logic rdy);
        mem_read_ex     = mr;
        rd_ex           = rd;
        rs1_id          = r1;
        rs1_used_id     = u1;
        rs2_id          = r2;
        rs2_used_id     = u2;
        branch_taken_ex = br;
        dmem_ready      = rdy;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic loadUse();
        applyStimulus(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #2;
        checkOutput("rst_pc_write", 16'(a_pc_write), 16'd1);
        checkOutput("rst_load_delay", 16'(b_load_delay), 16'd0);
        checkOutput("rst_stall_active", 16'(b_stall_active), 16'd0);
        checkOutput("rst_stall_cycles", b_stall_cycles, 16'd0);

        // hazard and memory-not-ready while in reset must not affect outputs
        applyStimulus(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("rst_forced_pc_write", 16'(b_pc_write), 16'd1);
        checkOutput("rst_forced_if_id_write", 16'(b_if_id_write), 16'd1);
        checkOutput("rst_forced_id_ex_write", 16'(b_id_ex_write), 16'd1);
        checkOutput("rst_forced_load_delay", 16'(b_load_delay), 16'd0);
        idle();
        tick();
        rst = 1'b0;

        $display("[TB] load-use on rs1");
        tick(); loadUse(); #2;
        checkOutput("lu1_a_load_delay", 16'(a_load_delay), 16'd1);
        checkOutput("lu1_a_pc_write", 16'(a_pc_write), 16'd0);
        checkOutput("lu1_a_if_id_write", 16'(a_if_id_write), 16'd0);
        checkOutput("lu1_a_id_ex_write", 16'(a_id_ex_write), 16'd1);
        checkOutput("lu1_b_load_delay", 16'(b_load_delay), 16'd1);
        tick(); idle(); #2;
        checkOutput("lu2_a_pc_write", 16'(a_pc_write), 16'd1);
        checkOutput("lu2_a_load_delay", 16'(a_load_delay), 16'd0);
        checkOutput("lu2_a_stall_active", 16'(a_stall_active), 16'd0);
        checkOutput("lu2_b_load_delay", 16'(b_load_delay), 16'd1);
        checkOutput("lu2_b_pc_write", 16'(b_pc_write), 16'd0);
        checkOutput("lu2_b_stall_active", 16'(b_stall_active), 16'd1);
        tick(); #2;
        checkOutput("lu3_b_load_delay", 16'(b_load_delay), 16'd1);
        checkOutput("lu3_b_stall_active", 16'(b_stall_active), 16'd1);
        tick(); #2;
        checkOutput("lu4_b_load_delay", 16'(b_load_delay), 16'd0);
        checkOutput("lu4_b_pc_write", 16'(b_pc_write), 16'd1);
        checkOutput("lu4_b_stall_active", 16'(b_stall_active), 16'd0);
        checkOutput("lu4_a_stall_cycles", 16'(a_stall_cycles), PERF ? 16'd1 : 16'd0);
        checkOutput("lu4_b_stall_cycles", b_stall_cycles, PERF ? 16'd3 : 16'd0);

        $display("[TB] x0 destination and unused rs2");
        tick(); applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1); #2;
        checkOutput("x0_a_load_delay", 16'(a_load_delay), 16'd0);
        checkOutput("x0_b_pc_write", 16'(b_pc_write), 16'd1);
        tick(); applyStimulus(1'b1, 5'd5, 5'd3, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1); #2;
        checkOutput("rs2unused_a_load_delay", 16'(a_load_delay), 16'd0);
        checkOutput("rs2unused_b_pc_write", 16'(b_pc_write), 16'd1);
        tick(); applyStimulus(1'b1, 5'd5, 5'd3, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1); #2;
        checkOutput("rs2used_a_load_delay", 16'(a_load_delay), 16'd1);
        checkOutput("rs2used_b_load_delay", 16'(b_load_delay), 16'd1);
        tick(); idle(); tick(); tick(); #2;
        checkOutput("rs2used_b_pc_write_after", 16'(b_pc_write), 16'd1);

        $display("[TB] taken branch together with load-use");
        tick(); applyStimulus(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1); #2;
        checkOutput("br_b_if_id_flush", 16'(b_if_id_flush), 16'd1);
        checkOutput("br_b_load_delay", 16'(b_load_delay), 16'd1);
        checkOutput("br_b_pc_write", 16'(b_pc_write), 16'd1);
        checkOutput("br_a_if_id_flush", 16'(a_if_id_flush), 16'd1);
        tick(); idle(); #2;
        checkOutput("br_next_b_stall_active", 16'(b_stall_active), 16'd0);
        checkOutput("br_next_b_load_delay", 16'(b_load_delay), 16'd0);

        $display("[TB] reset asserted mid-stall");
        tick(); loadUse(); #2;
        tick(); idle(); #2;
        checkOutput("mid_b_load_delay_before", 16'(b_load_delay), 16'd1);
        rst = 1'b1;
        #1;
        checkOutput("mid_b_load_delay_rst", 16'(b_load_delay), 16'd0);
        checkOutput("mid_b_pc_write_rst", 16'(b_pc_write), 16'd1);
        checkOutput("mid_b_stall_active_rst", 16'(b_stall_active), 16'd0);
        checkOutput("mid_b_stall_cycles_rst", b_stall_cycles, 16'd0);
        tick(); rst = 1'b0; #2;
        checkOutput("mid_b_no_residual", 16'(b_load_delay), 16'd0);
        checkOutput("mid_a_stall_cycles", 16'(a_stall_cycles), 16'd0);

        $display("[TB] memory wait during load-use hold");
        tick(); loadUse(); #2;
        checkOutput("mw1_b_load_delay", 16'(b_load_delay), 16'd1);
        tick(); applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); #2;
        checkOutput("mw2_b_pc_write", 16'(b_pc_write), 16'd0);
        checkOutput("mw2_b_id_ex_write", 16'(b_id_ex_write), 16'd0);
        checkOutput("mw2_b_load_delay", 16'(b_load_delay), 16'd0);
        checkOutput("mw2_a_if_id_write", 16'(a_if_id_write), 16'd0);
        checkOutput("mw2_a_id_ex_write", 16'(a_id_ex_write), 16'd0);
        checkOutput("mw2_a_load_delay", 16'(a_load_delay), 16'd0);
        tick(); applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1); #2;
        checkOutput("mw3_b_pc_write", 16'(b_pc_write), 16'd0);
        checkOutput("mw3_b_if_id_flush", 16'(b_if_id_flush), 16'd0);
        checkOutput("mw3_b_stall_active", 16'(b_stall_active), 16'd1);
        checkOutput("mw3_a_if_id_flush", 16'(a_if_id_flush), 16'd0);
        checkOutput("mw3_a_id_ex_write", 16'(a_id_ex_write), 16'd0);
        tick(); idle(); #2;
        checkOutput("mw4_b_load_delay", 16'(b_load_delay), 16'd1);
        checkOutput("mw4_b_pc_write", 16'(b_pc_write), 16'd0);
        checkOutput("mw4_a_pc_write", 16'(a_pc_write), 16'd1);
        tick(); #2;
        checkOutput("mw5_b_load_delay", 16'(b_load_delay), 16'd1);
        tick(); #2;
        checkOutput("mw6_b_pc_write", 16'(b_pc_write), 16'd1);
        checkOutput("mw6_b_load_delay", 16'(b_load_delay), 16'd0);
        checkOutput("mw6_b_stall_cycles", b_stall_cycles, PERF ? 16'd5 : 16'd0);
        checkOutput("mw6_a_stall_cycles", 16'(a_stall_cycles), PERF ? 16'd3 : 16'd0);

        $display("[TB] counter saturation on the 2-bit instance");
        tick(); loadUse(); #2;
        tick(); idle(); #2;
        checkOutput("sat_a_stall_cycles", 16'(a_stall_cycles), PERF ? 16'd3 : 16'd0);
        tick(); tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
